// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the RAM arbiter: command, address and write data in; ack and read data out.
interface mem_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 9
);
  logic [1:0]        cmd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output cmd, output addr, output wdata, input ack, input rdata);
  modport slave  (input cmd, input addr, input wdata, output ack, output rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read 256x16 RAM between port A (CPU) and port B.
// Every transaction walks IDLE -> ACCESS -> CAPTURE -> ACK; all outputs are registered.
module mem_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned RAM_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  mem_arbiter_if.slave      a,
  mem_arbiter_if.slave      b,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  localparam logic [1:0] MRead  = 2'd1;
  localparam logic [1:0] MWrite = 2'd2;

  typedef enum logic [1:0] {StIdle, StAccess, StCapture, StAck} state_e;

  state_e state_q;
  logic   owner_b_q;   // 1: port B owns the transaction in flight
  logic   last_b_q;    // 1: port B was granted last
  logic   rd_q;
  logic   unmapped_q;

  logic              a_req, b_req, grant_b;
  logic [1:0]        sel_cmd;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign a_req   = (a.cmd == MRead) || (a.cmd == MWrite);
  assign b_req   = (b.cmd == MRead) || (b.cmd == MWrite);
  // On a tie the port that did not win last time takes the grant.
  assign grant_b = b_req && (!a_req || !last_b_q);

  assign sel_cmd   = grant_b ? b.cmd   : a.cmd;
  assign sel_addr  = grant_b ? b.addr  : a.addr;
  assign sel_wdata = grant_b ? b.wdata : a.wdata;

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      owner_b_q  <= 1'b0;
      last_b_q   <= 1'b1;
      rd_q       <= 1'b0;
      unmapped_q <= 1'b0;
      a.ack      <= 1'b0;
      b.ack      <= 1'b0;
      a.rdata    <= '0;
      b.rdata    <= '0;
      ram_addr   <= '0;
      ram_din    <= '0;
      ram_write  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (a_req || b_req) begin
            owner_b_q  <= grant_b;
            rd_q       <= (sel_cmd == MRead);
            unmapped_q <= sel_addr[ADDR_W-1];
            ram_addr   <= sel_addr[RAM_AW-1:0];
            ram_din    <= sel_wdata;
            // Write strobe is set up here so it is high for exactly the ACCESS cycle.
            ram_write  <= (sel_cmd == MWrite) && !sel_addr[ADDR_W-1];
            state_q    <= StAccess;
          end
        end
        StAccess: begin
          ram_write <= 1'b0;
          state_q   <= StCapture;
        end
        StCapture: begin
          if (rd_q) begin
            if (owner_b_q) b.rdata <= unmapped_q ? '0 : ram_dout;
            else           a.rdata <= unmapped_q ? '0 : ram_dout;
          end
          a.ack   <= !owner_b_q;
          b.ack   <= owner_b_q;
          state_q <= StAck;
        end
        StAck: begin
          a.ack    <= 1'b0;
          b.ack    <= 1'b0;
          last_b_q <= owner_b_q;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous-read RAM.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [7:0]  ram_addr;
  logic        ram_write;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic        busy;

  mem_arbiter_if #(.DATA_W(16), .ADDR_W(9)) ai ();
  mem_arbiter_if #(.DATA_W(16), .ADDR_W(9)) bi ();

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .a         (ai),
    .b         (bi),
    .ram_addr  (ram_addr),
    .ram_write (ram_write),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .busy      (busy)
  );

  logic [15:0] mem [256];
  int          wr_cnt = 0;

  always @(posedge clk) begin
    if (ram_write) begin
      mem[ram_addr] <= ram_din;
      wr_cnt        <= wr_cnt + 1;
    end
    ram_dout <= mem[ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  ac;
    logic [8:0]  aa;
    logic [15:0] aw;
    logic [1:0]  bc;
    logic [8:0]  ba;
    logic [15:0] bw;
    logic        first_b;
    logic [15:0] exp_ar;
    logic [15:0] exp_br;
    int          exp_wr;
  } vec_t;

  function automatic int is_req(input logic [1:0] c);
    return (c == 2'd1 || c == 2'd2) ? 1 : 0;
  endfunction

  // Apply one request pair from IDLE; acks due 3 cycles after sampling, then every 4.
  task automatic do_vec(input vec_t v, input string nm);
    int   base, n, cyc, got;
    logic seen_b;
    @(negedge clk);
    ai.cmd = v.ac; ai.addr = v.aa; ai.wdata = v.aw;
    bi.cmd = v.bc; bi.addr = v.ba; bi.wdata = v.bw;
    base = wr_cnt;
    n    = is_req(v.ac) + is_req(v.bc);
    cyc  = 0;
    for (int k = 0; k < n; k++) begin
      got = 0;
      while (got == 0 && cyc < 16) begin
        @(posedge clk); #1;
        cyc++;
        if (ai.ack || bi.ack) got = 1;
      end
      chk({nm, " latency"}, cyc, 3 + 4 * k);
      seen_b = bi.ack;
      if (got != 0) begin
        chk({nm, " ack port"}, {31'd0, seen_b}, {31'd0, (k == 0) ? v.first_b : !v.first_b});
        chk({nm, " ack exclusive"}, {31'd0, ai.ack & bi.ack}, 32'd0);
      end
      @(negedge clk);
      if (seen_b) bi.cmd = 2'd0;
      else        ai.cmd = 2'd0;
    end
    chk({nm, " a_rdata"}, {16'd0, ai.rdata}, {16'd0, v.exp_ar});
    chk({nm, " b_rdata"}, {16'd0, bi.rdata}, {16'd0, v.exp_br});
    chk({nm, " ram writes"}, wr_cnt - base, v.exp_wr);
  endtask

  vec_t vecs [10];

  initial begin
    int cyc, got, k;
    logic acc;

    vecs[0] = '{2'd2, 9'h005, 16'hBEEF, 2'd0, 9'h000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1};
    vecs[1] = '{2'd1, 9'h005, 16'h0000, 2'd0, 9'h000, 16'h0000, 1'b0, 16'hBEEF, 16'h0000, 0};
    vecs[2] = '{2'd2, 9'h001, 16'h1111, 2'd2, 9'h002, 16'h2222, 1'b1, 16'hBEEF, 16'h0000, 2};
    vecs[3] = '{2'd1, 9'h001, 16'h0000, 2'd1, 9'h002, 16'h0000, 1'b1, 16'h1111, 16'h2222, 0};
    vecs[4] = '{2'd2, 9'h105, 16'h1234, 2'd0, 9'h000, 16'h0000, 1'b0, 16'h1111, 16'h2222, 0};
    vecs[5] = '{2'd1, 9'h105, 16'h0000, 2'd0, 9'h000, 16'h0000, 1'b0, 16'h0000, 16'h2222, 0};
    vecs[6] = '{2'd1, 9'h005, 16'h0000, 2'd0, 9'h000, 16'h0000, 1'b0, 16'hBEEF, 16'h2222, 0};
    vecs[7] = '{2'd3, 9'h005, 16'h0000, 2'd1, 9'h105, 16'h0000, 1'b1, 16'hBEEF, 16'h0000, 0};
    vecs[8] = '{2'd0, 9'h000, 16'h0000, 2'd2, 9'h0FF, 16'hABCD, 1'b1, 16'hBEEF, 16'h0000, 1};
    vecs[9] = '{2'd1, 9'h0FF, 16'h0000, 2'd1, 9'h005, 16'h0000, 1'b0, 16'hABCD, 16'hBEEF, 0};

    ai.cmd = 2'd0; ai.addr = '0; ai.wdata = '0;
    bi.cmd = 2'd0; bi.addr = '0; bi.wdata = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset acks", {30'd0, ai.ack, bi.ack}, 32'd0);
    chk("reset rdata", {ai.rdata, bi.rdata}, 32'd0);
    chk("reset ram_write", {31'd0, ram_write}, 32'd0);
    chk("reset ram_addr/din", {8'd0, ram_addr, ram_din}, 32'd0);
    @(negedge clk) reset = 1'b0;

    // Write strobe: one ACCESS cycle with the latched address and data.
    @(negedge clk);
    ai.cmd = 2'd2; ai.addr = 9'h0AA; ai.wdata = 16'h5A5A;
    @(posedge clk); #1;
    chk("wr pulse access", {7'd0, busy, ram_write, ram_addr, ram_din}, {7'd0, 1'b1, 1'b1, 8'hAA, 16'h5A5A});
    @(posedge clk); #1;
    chk("wr pulse capture", {31'd0, ram_write}, 32'd0);
    chk("wr pulse no early ack", {31'd0, ai.ack}, 32'd0);
    @(posedge clk); #1;
    chk("wr pulse ack", {30'd0, ai.ack, bi.ack}, 32'd2);
    @(negedge clk) ai.cmd = 2'd0;

    for (int i = 0; i < 10; i++) do_vec(vecs[i], $sformatf("vec%0d", i));

    // Both ports hold reads: grants must alternate A, B, ... every 4 cycles.
    @(negedge clk);
    ai.cmd = 2'd1; ai.addr = 9'h005;
    bi.cmd = 2'd1; bi.addr = 9'h0FF;
    cyc = 0;
    k   = 0;
    while (k < 8 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (ai.ack || bi.ack) begin
        chk($sformatf("contend ack%0d port", k), {30'd0, ai.ack, bi.ack},
            (k % 2 == 0) ? 32'd2 : 32'd1);
        chk($sformatf("contend ack%0d time", k), cyc, 3 + 4 * k);
        k++;
      end
    end
    chk("contend ack count", k, 8);
    @(negedge clk);
    ai.cmd = 2'd0; bi.cmd = 2'd0;
    chk("contend data", {ai.rdata, bi.rdata}, {16'hBEEF, 16'hABCD});

    // Reset while B's read is in CAPTURE.
    @(negedge clk);
    bi.cmd = 2'd1; bi.addr = 9'h0FF;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre-reset busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid reset busy", {31'd0, busy}, 32'd0);
    chk("mid reset b_ack", {31'd0, bi.ack}, 32'd0);
    chk("mid reset rdata", {ai.rdata, bi.rdata}, 32'd0);
    bi.cmd = 2'd0;
    @(negedge clk) reset = 1'b0;
    acc = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      acc = acc | bi.ack | ai.ack;
    end
    chk("post reset no ack", {31'd0, acc}, 32'd0);
    do_vec('{2'd1, 9'h005, 16'h0000, 2'd1, 9'h0FF, 16'h0000, 1'b0, 16'hBEEF, 16'hABCD, 0},
           "tie after reset");

    // cmd=3 on both ports behaves as no request.
    @(negedge clk);
    ai.cmd = 2'd3; ai.addr = 9'h005;
    bi.cmd = 2'd3; bi.addr = 9'h0FF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("cmd3 idle c%0d", i), {28'd0, busy, ai.ack, bi.ack, ram_write}, 32'd0);
    end
    ai.cmd = 2'd0; bi.cmd = 2'd0;

    got = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
